btn_step_gen: RTL and testbench

Upstream step-trigger generator for the LFSR/seven-segment display path. It takes a raw, bouncy push-button. It synchronises and debounces the button, then emits clean single-cycle step pulses on `o_rand_flag`, which feed the LFSR's `i_rand_flag` step input. Holding the button produces auto-repeat steps. An 8-bit press/step counter is exported for LED or debug use.

---
 rtl/btn_step_gen_if.sv | 22 ++
 rtl/btn_step_gen.sv | 138 +++++++++++++
 tb/tb_btn_step_gen.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/btn_step_gen_if.sv
// Button/step-pulse signal bundle between the button conditioner and its user.
// The design takes the slave side; the driver of the raw button takes master.
interface btn_step_gen_if;
  logic       i_btn;
  logic       o_rand_flag;
  logic       o_btn_level;
  logic [7:0] o_step_cnt;

  modport master (
    output i_btn,
    input  o_rand_flag,
    input  o_btn_level,
    input  o_step_cnt
  );

  modport slave (
    input  i_btn,
    output o_rand_flag,
    output o_btn_level,
    output o_step_cnt
  );
endinterface

// File: rtl/btn_step_gen.sv
// Push-button conditioner: synchronise, debounce, then emit single-cycle step
// pulses with auto-repeat while held, plus an 8-bit count of issued pulses.
module btn_step_gen #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic           clk,
  input  logic           rst,
  btn_step_gen_if.slave  bus
);

  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX + 1) : 1;

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD_DELAY,
    HOLD_REPEAT,
    HOLD_WAIT
  } state_t;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_level_q, db_level_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  state_t           state_q, state_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             flag_q, flag_d;
  logic [7:0]       step_cnt_q, step_cnt_d;
  logic             pulse;

  // Stage 1: two-flop synchroniser for the asynchronous button
  always_comb begin
    sync1_d = bus.i_btn;
    sync2_d = sync1_q;
  end

  // Stage 2: debouncer; level flips only after DEBOUNCE_CYCLES consecutive disagreements
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    if (sync2_q != db_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_level_d = ~db_level_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // Stage 3: press/auto-repeat FSM; release wins over a repeat due on the same cycle
  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q;
    pulse     = 1'b0;
    case (state_q)
      IDLE: begin
        rep_cnt_d = '0;
        if (db_level_q) begin
          pulse   = 1'b1;
          state_d = (REPEAT_DELAY == 0) ? HOLD_WAIT : HOLD_DELAY;
        end
      end
      HOLD_DELAY: begin
        if (!db_level_q) begin
          state_d   = IDLE;
          rep_cnt_d = '0;
        end else if (rep_cnt_q == DELAY_LAST) begin
          pulse     = 1'b1;
          rep_cnt_d = '0;
          state_d   = HOLD_REPEAT;
        end else begin
          rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
      end
      HOLD_REPEAT: begin
        if (!db_level_q) begin
          state_d   = IDLE;
          rep_cnt_d = '0;
        end else if (rep_cnt_q == PERIOD_LAST) begin
          pulse     = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
      end
      HOLD_WAIT: begin
        if (!db_level_q) begin
          state_d   = IDLE;
          rep_cnt_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        rep_cnt_d = '0;
      end
    endcase
  end

  // Stage 4: registered pulse and wrapping step counter
  always_comb begin
    flag_d     = pulse;
    step_cnt_d = step_cnt_q + {7'd0, pulse};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_level_q <= 1'b0;
      db_cnt_q   <= '0;
      state_q    <= IDLE;
      rep_cnt_q  <= '0;
      flag_q     <= 1'b0;
      step_cnt_q <= 8'd0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      state_q    <= state_d;
      rep_cnt_q  <= rep_cnt_d;
      flag_q     <= flag_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign bus.o_rand_flag = flag_q;
  assign bus.o_btn_level = db_level_q;
  assign bus.o_step_cnt  = step_cnt_q;

endmodule

// File: tb/tb_btn_step_gen.sv
// Scoreboard bench for btn_step_gen: directed button sequences queue the
// expected pulse edges and counts; a monitor checks every pulse as it appears.
module tb_btn_step_gen;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  btn_step_gen_if bus ();

  btn_step_gen #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at_edge;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic       prev_flag = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0h, want %0h", name, cyc, act, req);
    end
  endtask

  task automatic expect_pulse(input int e);
    exp_t item;
    exp_cnt      = exp_cnt + 8'd1;
    item.at_edge = e;
    item.cnt     = exp_cnt;
    sb_q.push_back(item);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_flag"},  bus.o_rand_flag, 0);
    chk({name, "_level"}, bus.o_btn_level, 0);
    chk({name, "_cnt"},   bus.o_step_cnt,  0);
  endtask

  // Monitor: every pulse must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (bus.o_rand_flag === 1'b1) begin
      chk("pulse_width", prev_flag, 0);
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse at edge %0d: cnt %0h, want no pulse", cyc, bus.o_step_cnt);
      end else begin
        e = sb_q.pop_front();
        chk("pulse_edge", cyc, e.at_edge);
        chk("pulse_cnt", bus.o_step_cnt, e.cnt);
      end
    end
    prev_flag = (bus.o_rand_flag === 1'b1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int p;
    logic [5:0] pat;

    // Reset with the button toggling
    rst = 1'b1;
    bus.i_btn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.i_btn = ~bus.i_btn;
      @(negedge clk);
      chk_all_zero("reset");
    end
    rst = 1'b0;
    bus.i_btn = 1'b0;
    wait_until(9);
    chk_all_zero("post_reset");

    // Clean press, first sampled at edge 10, held 8 samples
    s = cyc + 1;
    bus.i_btn = 1'b1;
    expect_pulse(s + 2 + D);
    wait_until(s + D);
    chk("press_level_early", bus.o_btn_level, 0);
    wait_until(s + 1 + D);
    chk("press_level_rise", bus.o_btn_level, 1);
    wait_until(s + 7);
    bus.i_btn = 1'b0;
    wait_until(s + 12);
    chk("release_level_hold", bus.o_btn_level, 1);
    wait_until(s + 13);
    chk("release_level_fall", bus.o_btn_level, 0);
    wait_until(s + 25);
    chk("press_cnt", bus.o_step_cnt, 1);

    // Bounce 1,0,1,1,0 then stable 1
    pat = 6'b101101;
    for (int i = 0; i < 5; i++) begin
      bus.i_btn = pat[i];
      @(negedge clk);
      chk("bounce_level", bus.o_btn_level, 0);
    end
    s = cyc + 1;
    bus.i_btn = 1'b1;
    expect_pulse(s + 2 + D);
    for (int t = s; t <= s + 11; t++) begin
      wait_until(t);
      chk("bounce_level_track", bus.o_btn_level, (t >= s + 1 + D) ? 1 : 0);
      if (t == s + 6) bus.i_btn = 1'b0;
    end
    wait_until(s + 12);
    chk("bounce_level_fall", bus.o_btn_level, 0);
    wait_until(s + 25);
    chk("bounce_cnt", bus.o_step_cnt, 2);

    // Hold with auto-repeat; release lands before the pulse due at p+31
    s = cyc + 1;
    p = s + 2 + D;
    bus.i_btn = 1'b1;
    expect_pulse(p);
    expect_pulse(p + RD);
    for (int k = 1; k <= 6; k++) expect_pulse(p + RD + k * RP);
    wait_until(p + 23);
    bus.i_btn = 1'b0;
    wait_until(p + 45);
    chk("repeat_cnt", bus.o_step_cnt, 10);
    chk("repeat_level_after", bus.o_btn_level, 0);

    // Preload to 255 with a long hold, then one more press wraps to 0
    s = cyc + 1;
    p = s + 2 + D;
    bus.i_btn = 1'b1;
    expect_pulse(p);
    for (int k = 0; k < 244; k++) expect_pulse(p + RD + k * RP);
    wait_until(p + 734);
    bus.i_btn = 1'b0;
    wait_until(p + 760);
    chk("preload_cnt", bus.o_step_cnt, 8'hFF);
    s = cyc + 1;
    bus.i_btn = 1'b1;
    expect_pulse(s + 2 + D);
    wait_until(s + 1 + D);
    chk("wrap_cnt_before", bus.o_step_cnt, 8'hFF);
    wait_until(s + 2 + D);
    chk("wrap_cnt_after", bus.o_step_cnt, 8'h00);
    wait_until(s + 7);
    bus.i_btn = 1'b0;
    wait_until(s + 25);

    // Reset mid-repeat, one cycle before the pulse due at p+16
    s = cyc + 1;
    p = s + 2 + D;
    bus.i_btn = 1'b1;
    expect_pulse(p);
    expect_pulse(p + RD);
    expect_pulse(p + RD + RP);
    wait_until(p + 14);
    rst = 1'b1;
    for (int t = p + 15; t <= p + 17; t++) begin
      wait_until(t);
      chk_all_zero("mid_reset");
    end
    rst = 1'b0;
    exp_cnt = 8'd0;
    s = cyc + 1;
    expect_pulse(s + 2 + D);
    wait_until(s + D);
    chk("rehold_level_early", bus.o_btn_level, 0);
    wait_until(s + 1 + D);
    chk("rehold_level_rise", bus.o_btn_level, 1);
    wait_until(s + 7);
    bus.i_btn = 1'b0;
    wait_until(s + 25);
    chk("rehold_cnt", bus.o_step_cnt, 1);

    chk("pending_pulses", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
